// File: rtl/ball_square_object.sv
`default_nettype none
// ============================================================================
//  Module      : ball_square_object
//  Description : Owns one ball's screen position and per-frame motion
//                (horizontal drift, gravity, floor bounce, wall/ceiling
//                reflection), and tests every scan pixel against the ball's
//                bounding box. It drives the registered offset/inside triple
//                that feeds the ball bitmap stage.
//  Ports       : clk, reset (async, active-high)
//                pixelX/pixelY    - current scan position
//                startOfFrame     - one pulse per frame, advances motion
//                launch / hit     - (re)spawn / pop the ball
//                offsetX/offsetY  - pixel offset inside the box (registered)
//                InsideRectangle  - pixel inside box and ball active (registered)
//                ballActive       - ball currently shown
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_square_object #(
    parameter int OBJECT_WIDTH_X  = 32,
    parameter int OBJECT_HEIGHT_Y = 32,
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 100,
    parameter int INIT_VX         = 2,
    parameter int GRAVITY         = 1,
    parameter int GRAVITY_DIV     = 2,
    parameter int BOUNCE_VY       = 10,
    parameter int LEFT_X          = 0,
    parameter int RIGHT_X         = 640,
    parameter int TOP_Y           = 0,
    parameter int FLOOR_Y         = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        launch,
    input  logic        hit,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        ballActive
);

    localparam int GCW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

    // 12-bit signed working constants for the motion arithmetic
    localparam logic signed [11:0] C_W        = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] C_H        = 12'(OBJECT_HEIGHT_Y);
    localparam logic signed [11:0] C_LEFT     = 12'(LEFT_X);
    localparam logic signed [11:0] C_RIGHT    = 12'(RIGHT_X);
    localparam logic signed [11:0] C_TOP      = 12'(TOP_Y);
    localparam logic signed [11:0] C_FLOOR    = 12'(FLOOR_Y);
    localparam logic signed [11:0] C_RIGHT_TX = C_RIGHT - C_W;
    localparam logic signed [11:0] C_FLOOR_TY = C_FLOOR - C_H;
    localparam logic        [10:0] C_INIT_X   = 11'(INIT_X);
    localparam logic        [10:0] C_INIT_Y   = 11'(INIT_Y);
    localparam logic signed [7:0]  C_INIT_VX  = 8'(INIT_VX);
    localparam logic signed [7:0]  C_BOUNCE   = 8'(-BOUNCE_VY);
    localparam logic signed [8:0]  C_GRAV     = 9'(GRAVITY);
    localparam logic signed [8:0]  C_VY_MAX   = 9'sd127;
    localparam logic [GCW-1:0]     C_GCNT_TOP = GCW'(GRAVITY_DIV - 1);
    localparam logic [11:0]        C_W_U      = 12'(OBJECT_WIDTH_X);
    localparam logic [11:0]        C_H_U      = 12'(OBJECT_HEIGHT_Y);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        top_x_q, top_x_d;
    logic [10:0]        top_y_q, top_y_d;
    logic signed [7:0]  vx_q, vx_d;
    logic signed [7:0]  vy_q, vy_d;
    logic [GCW-1:0]     grav_cnt_q, grav_cnt_d;

    logic [10:0]        offset_x_q, offset_y_q;
    logic               inside_q;

    // Motion intermediates
    logic signed [11:0] nx, ny;
    logic signed [7:0]  vy_base;
    logic signed [8:0]  vy_sum;
    logic               floor_hit;
    logic               grav_wrap;

    // Rectangle-test intermediates
    logic [11:0]        px_u, py_u, tx_u, ty_u;
    logic               inside_d;

    // ------------------------------------------------------------------
    // Next-state: FSM plus motion update
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        top_x_d    = top_x_q;
        top_y_d    = top_y_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        grav_cnt_d = grav_cnt_q;

        nx        = $signed({1'b0, top_x_q}) + $signed({{4{vx_q[7]}}, vx_q});
        ny        = $signed({1'b0, top_y_q}) + $signed({{4{vy_q[7]}}, vy_q});
        floor_hit = (ny + C_H) >= C_FLOOR;
        grav_wrap = (grav_cnt_q == C_GCNT_TOP);
        vy_base   = vy_q;
        vy_sum    = '0;

        // hit has priority over launch; launch respawns in either state
        if (hit) begin
            state_d = ST_IDLE;
        end else if (launch) begin
            state_d    = ST_ACTIVE;
            top_x_d    = C_INIT_X;
            top_y_d    = C_INIT_Y;
            vx_d       = C_INIT_VX;
            vy_d       = '0;
            grav_cnt_d = '0;
        end else if (startOfFrame && (state_q == ST_ACTIVE)) begin
            // Horizontal: clamp to the wall and reflect
            if (nx < C_LEFT) begin
                top_x_d = C_LEFT[10:0];
                vx_d    = -vx_q;
            end else if ((nx + C_W) > C_RIGHT) begin
                top_x_d = C_RIGHT_TX[10:0];
                vx_d    = -vx_q;
            end else begin
                top_x_d = nx[10:0];
            end

            // Vertical: floor beats ceiling beats free flight
            if (floor_hit) begin
                top_y_d = C_FLOOR_TY[10:0];
            end else if (ny < C_TOP) begin
                top_y_d = C_TOP[10:0];
                vy_base = '0;
            end else begin
                top_y_d = ny[10:0];
            end

            grav_cnt_d = grav_wrap ? '0 : grav_cnt_q + 1'b1;

            // A bounce frame takes the fixed rebound speed with no gravity
            vy_sum = $signed({vy_base[7], vy_base}) + C_GRAV;
            if (floor_hit) begin
                vy_d = C_BOUNCE;
            end else if (grav_wrap) begin
                vy_d = (vy_sum > C_VY_MAX) ? 8'sd127 : vy_sum[7:0];
            end else begin
                vy_d = vy_base;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rectangle test against the position held in the registers now
    // (a startOfFrame cycle therefore sees the pre-update position)
    // ------------------------------------------------------------------
    always_comb begin
        px_u     = {1'b0, pixelX};
        py_u     = {1'b0, pixelY};
        tx_u     = {1'b0, top_x_q};
        ty_u     = {1'b0, top_y_q};
        inside_d = (state_q == ST_ACTIVE)
                   && (px_u >= tx_u) && (px_u < (tx_u + C_W_U))
                   && (py_u >= ty_u) && (py_u < (ty_u + C_H_U));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            top_x_q    <= C_INIT_X;
            top_y_q    <= C_INIT_Y;
            vx_q       <= C_INIT_VX;
            vy_q       <= '0;
            grav_cnt_q <= '0;
            offset_x_q <= '0;
            offset_y_q <= '0;
            inside_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            top_x_q    <= top_x_d;
            top_y_q    <= top_y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            grav_cnt_q <= grav_cnt_d;
            inside_q   <= inside_d;
            offset_x_q <= inside_d ? (pixelX - top_x_q) : 11'd0;
            offset_y_q <= inside_d ? (pixelY - top_y_q) : 11'd0;
        end
    end

    assign offsetX         = offset_x_q;
    assign offsetY         = offset_y_q;
    assign InsideRectangle = inside_q;
    assign ballActive      = (state_q == ST_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_ball_square_object.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_square_object
//  Description : Directed self-checking bench for ball_square_object. Four
//                instances with different spawn parameters share one stimulus
//                stream; ball positions are observed through the pixel
//                offsets reported when probing inside the box.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_square_object;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, launch, hit;

    logic [10:0] ox [0:3];
    logic [10:0] oy [0:3];
    logic [3:0]  ins;
    logic [3:0]  act;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // 0: defaults   1: floor bounce   2: right wall   3: left wall
    ball_square_object u_dut0 (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .launch(launch), .hit(hit),
        .offsetX(ox[0]), .offsetY(oy[0]), .InsideRectangle(ins[0]), .ballActive(act[0]));

    ball_square_object #(.INIT_Y(446), .INIT_VX(0)) u_dut1 (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .launch(launch), .hit(hit),
        .offsetX(ox[1]), .offsetY(oy[1]), .InsideRectangle(ins[1]), .ballActive(act[1]));

    ball_square_object #(.INIT_X(606), .INIT_VX(4)) u_dut2 (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .launch(launch), .hit(hit),
        .offsetX(ox[2]), .offsetY(oy[2]), .InsideRectangle(ins[2]), .ballActive(act[2]));

    ball_square_object #(.INIT_X(1), .INIT_VX(-3)) u_dut3 (
        .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .launch(launch), .hit(hit),
        .offsetX(ox[3]), .offsetY(oy[3]), .InsideRectangle(ins[3]), .ballActive(act[3]));

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a pixel for one cycle and check instance k's registered result
    task automatic probe(input int k, input string tag, input int px, input int py,
                         input int exp_in, input int exp_ox, input int exp_oy);
        @(negedge clk);
        pixelX = 11'(px);
        pixelY = 11'(py);
        @(posedge clk);
        #1;
        check({tag, ".in"}, int'(ins[k]), exp_in);
        check({tag, ".ox"}, int'(ox[k]),  exp_ox);
        check({tag, ".oy"}, int'(oy[k]),  exp_oy);
    endtask

    // One-cycle startOfFrame pulse with the pixel parked at (px,py)
    task automatic frame(input int px, input int py);
        @(negedge clk);
        pixelX       = 11'(px);
        pixelY       = 11'(py);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic pulse(input logic l, input logic h);
        @(negedge clk);
        launch = l;
        hit    = h;
        @(negedge clk);
        launch = 1'b0;
        hit    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pixelX = '0; pixelY = '0;
        startOfFrame = 1'b0; launch = 1'b0; hit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in",  int'(ins[0]), 0);
        check("rst.act", int'(act[0]), 0);
        check("rst.ox",  int'(ox[0]),  0);
        @(negedge clk);
        reset = 1'b0;

        probe(0, "idle", 100, 100, 0, 0, 0);

        // hit and startOfFrame while idle: no effect
        pulse(1'b0, 1'b1);
        check("hit_idle.act", int'(act[0]), 0);
        frame(100, 100);
        check("sof_idle.act", int'(act[0]), 0);

        pulse(1'b1, 1'b0);
        check("launch.act0", int'(act[0]), 1);
        check("launch.act3", int'(act[3]), 1);

        probe(0, "corner_tl", 100, 100, 1, 0, 0);
        probe(0, "corner_br", 131, 131, 1, 31, 31);
        probe(0, "right_out", 132, 100, 0, 0, 0);
        probe(0, "left_out",   99, 110, 0, 0, 0);
        probe(0, "below_out", 110, 132, 0, 0, 0);

        // Frame 1: the startOfFrame cycle still sees topX=100
        @(negedge clk);
        pixelX = 11'd100; pixelY = 11'd100; startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        check("sof_pre.in", int'(ins[0]), 1);
        check("sof_pre.ox", int'(ox[0]),  0);
        @(negedge clk);
        startOfFrame = 1'b0;
        probe(0, "f1.d0",   102, 100, 1, 0, 0);
        probe(0, "f1.d0l",  101, 100, 0, 0, 0);
        probe(1, "f1.d1",   100, 450, 1, 0, 4);
        probe(2, "f1.d2",   613, 105, 1, 5, 5);   // clamped to 608
        probe(3, "f1.d3",     5, 105, 1, 5, 5);   // clamped to 0

        frame(0, 0);                              // frame 2: vy becomes 1
        probe(0, "f2.d0",   110, 110, 1, 6, 10);  // (104,100)
        probe(1, "f2.d1",   100, 450, 1, 0, 4);   // 446
        probe(2, "f2.d2",   610, 105, 1, 6, 5);   // 604
        probe(3, "f2.d3",     5, 105, 1, 2, 5);   // 3

        frame(0, 0);                              // frame 3
        probe(0, "f3.d0",   110, 110, 1, 4, 9);   // (106,101)
        probe(1, "f3.d1",   100, 450, 1, 0, 3);   // 447

        frame(0, 0);                              // frame 4: floor bounce
        probe(1, "f4.d1",   100, 450, 1, 0, 2);   // 448
        probe(0, "f4.d0",   110, 110, 1, 2, 8);   // (108,102)

        frame(0, 0);                              // frame 5
        probe(1, "f5.d1",   100, 450, 1, 0, 12);  // 438
        probe(0, "f5.d0",   115, 110, 1, 5, 6);   // (110,104)

        // hit and launch together: hit wins
        pulse(1'b1, 1'b1);
        check("hitlaunch.act", int'(act[0]), 0);
        probe(0, "hitlaunch", 115, 110, 0, 0, 0);

        // Respawn, then asynchronous reset in the middle of a cycle
        pulse(1'b1, 1'b0);
        probe(0, "respawn", 105, 107, 1, 5, 7);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst.in",  int'(ins[0]), 0);
        check("arst.ox",  int'(ox[0]),  0);
        check("arst.oy",  int'(oy[0]),  0);
        check("arst.act", int'(act[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        probe(0, "post_rst", 100, 100, 0, 0, 0);
        check("post_rst.act", int'(act[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
